// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// State encoding, grant indices and read-latency bounds.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LDR = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes
// to the side that was not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o,
  output logic       any_o
);

  assign any_o = |req_i;

  always_comb begin
    winner_o = GNT_CPU;
    unique case (1'b1)
      (req_i == 2'b11): winner_o = ~last_grant_i;
      (req_i == 2'b10): winner_o = GNT_LDR;
      default:          winner_o = GNT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared instruction/data memory port:
// one access in flight, single write strobe, registered ready.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_readdata
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(RD_LAT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_q;
  logic             we_q;
  logic             last_q;
  logic [AW-1:0]    adr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata0_q;
  logic [DW-1:0]    rdata1_q;
  logic [1:0]       ready_q;
  logic             winner;
  logic             any_req;

  rr_pick2 u_pick (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_q),
    .winner_o     (winner),
    .any_o        (any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= GNT_CPU;
      we_q     <= 1'b0;
      last_q   <= GNT_LDR;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ready_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= winner;
            we_q    <= winner ? m1_we : m0_we;
            adr_q   <= winner ? m1_adr : m0_adr;
            wdata_q <= winner ? m1_wdata : m0_wdata;
            cnt_q   <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (we_q || cnt_q == CNT_LAST) begin
            if (!we_q && gnt_q == GNT_LDR)
              rdata1_q <= mem_readdata;
            if (!we_q && gnt_q == GNT_CPU)
              rdata0_q <= mem_readdata;
            ready_q <= gnt_q ? 2'b10 : 2'b01;
            state_q <= RESP;
          end
        end
        RESP: begin
          ready_q <= '0;
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobe only in the first ACCESS cycle; reset kills it at once.
  assign mem_memwrite = (state_q == ACCESS) && we_q
                        && (cnt_q == '0);
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign m0_ready  = ready_q[0];
  assign m1_ready  = ready_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single unified instruction/data memory port of the multicycle MIPS core. It grants the port to the processor (requester 0) or to a loader/DMA engine (requester 1) with round-robin fairness. It holds the address for a parameterised read latency, issues exactly one write strobe per write, and returns a one-cycle `ready` pulse with registered read data. Its `m0_ready` output is the processor's stall/advance qualifier.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `RD_LAT`, default 1: memory read latency in cycles. Legal range is 1..8.

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  processor request; held high until `m0_ready` is sampled.
- `m0_we`  in  1  processor write (1) / read (0); stable while `m0_req` is high.
- `m0_adr`  in  AW  processor address.
- `m0_wdata`  in  DW  processor write data.
- `m0_ready`  out  1  one-cycle completion pulse to the processor.
- `m0_rdata`  out  DW  read data; valid while `m0_ready` is high.
- `m1_req`, `m1_we`, `m1_adr`, `m1_wdata`, `m1_ready`, `m1_rdata`: same definitions as the m0 ports, for the loader/DMA requester.
- `mem_adr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_memwrite`  out  1  memory write strobe.
- `mem_readdata`  in  DW  memory read data, valid `RD_LAT` cycles after the address is presented.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req` is high, choose a winner and register `adr`, `we`, `wdata` and the grant index. Clear `cnt`. Move to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - A single requester wins unconditionally.
  - When both request, the one not granted last wins.
  - `last_grant` resets to 1, so m0 wins the first tie.
- **ACCESS:**
  - `mem_adr` and `mem_wdata` come from the registered request.
  - `mem_memwrite` = `we` AND (`cnt` == 0), so each write produces exactly one strobe cycle.
  - A write moves to RESP after one ACCESS cycle.
  - A read increments `cnt`. When `cnt` == `RD_LAT`-1, it captures `mem_readdata` into the granted requester's `rdata` register and moves to RESP.
- **RESP:**
  - Assert `ready` of the granted requester only, and update `last_grant`.
  - Return to IDLE.
  - `req` is ignored in this state.
- **Handshake:**
  - A requester deasserts `req`, or changes to its next request, on the same edge at which it samples `ready` high.
  - A requester that keeps `req` high is treated as issuing a new request in the following IDLE cycle.
- **Read data:** the non-granted requester's `rdata` is unchanged. Each `rdata` holds its value until that requester's next read completes.
- **Idle outputs:** while idle, `mem_adr`/`mem_wdata` hold the last registered values and `mem_memwrite` is 0.
- **Reset values:**
  - State IDLE; all registers 0; `last_grant` = 1.
  - `mem_memwrite`, `m0_ready`, `m1_ready` = 0.
  - `m0_rdata`, `m1_rdata`, `mem_adr`, `mem_wdata` = 0.
- **Reset mid-operation:** any in-flight access is aborted immediately. `mem_memwrite` drops asynchronously, no `ready` is issued, and the aborted request must be reissued.
- **Request changes:** a requester that drops `req` before `ready` is a protocol violation. The captured access still completes and `ready` is still pulsed.

## Timing
- Request first sampled high in IDLE at edge 0:
  - Write: `mem_memwrite` is high in cycle 1; `ready` is high in cycle 2.
  - Read: address is presented in cycles 1..`RD_LAT`; `ready` is high in cycle `RD_LAT`+1.
- The memory sees at most one access in flight, so there is no pipelining.
- Back-to-back accesses from one requester cost one IDLE cycle between the RESP and ACCESS phases:
  - Write-to-write spacing is 3 cycles.
  - Read spacing is `RD_LAT`+2 cycles.
- Under constant contention, grants strictly alternate m0, m1, m0, …
- `ready` outputs are registered and never combinationally dependent on `req`.

## Structure
- Shared package `mem_arb_pkg`: state encoding localparams (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2), grant index constants (GNT_CPU = 0, GNT_LDR = 1), and the `RD_LAT` legal-range check constant.
- One natural sub-module, `rr_pick2`: a combinational two-way round-robin picker taking `req[1:0]` and `last_grant` and producing `winner` and `any`. The `last_grant` flop stays in the parent.
- The parent holds the FSM, the 3-bit `cnt`, the request capture registers and the two `rdata` registers.

## Test plan
- **Write then read:** with `RD_LAT`=1, m0 writes 0xDEADBEEF to 0x40, then reads 0x40. Required: `mem_memwrite` is high exactly 1 cycle; `m0_ready` is high in cycle 2 for the write; `m0_rdata` = 0xDEADBEEF in cycle 2 of the read.
- **Read latency sweep:** `RD_LAT`=4, m1 reads 0x100 from a memory model that returns 0x1234 after 4 cycles. Required: `m1_ready` is high only in cycle 5; `m0_rdata` is unchanged.
- **Contention:** both requesters hold `req` continuously for 6 reads. Required: grant order m0, m1, m0, m1, m0, m1, and no `ready` overlap.
- **Write strobe count:** m1 issues 3 consecutive writes. Required: exactly 3 single-cycle `mem_memwrite` pulses, spaced 3 cycles apart, with matching addresses.
- **Reset mid-access:** assert `reset` during ACCESS of a write with `RD_LAT`=4. Required: `mem_memwrite` drops immediately; both `ready` signals stay 0; state returns to IDLE; the first tie after release goes to m0.
- **Held request:** m0 keeps `req` high past `ready`. Required: a second access starts after exactly one IDLE cycle.
